// File: rtl/stack_regfile.sv
// Register cache for the top NREGS Lua stack slots (value + type tag),
// with three read ports, one core write port and an Avalon-MM fill/flush engine.
// Ports: clk, rst (async, active-low); cmd_valid/cmd_op/cmd_base/cmd_count,
//   cmd_ready/done command handshake; idx_a/b/c -> data_*/type_* reads;
//   wdata_a/wtype_a/wdata_en/wtype_en core write to slot idx_a; base;
//   mem_* Avalon-MM master.
module stack_regfile #(
  parameter int NREGS      = 32,
  parameter int TTAG_SIZE  = 5,
  parameter int SLOT_SHIFT = 3,
  localparam int IDX_W     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [31:0]          cmd_base,
  input  logic [IDX_W:0]       cmd_count,
  output logic                 cmd_ready,
  output logic                 done,
  input  logic [IDX_W-1:0]     idx_a,
  input  logic [IDX_W-1:0]     idx_b,
  input  logic [IDX_W-1:0]     idx_c,
  output logic [31:0]          data_a,
  output logic [31:0]          data_b,
  output logic [31:0]          data_c,
  output logic [TTAG_SIZE-1:0] type_a,
  output logic [TTAG_SIZE-1:0] type_b,
  output logic [TTAG_SIZE-1:0] type_c,
  input  logic [31:0]          wdata_a,
  input  logic [TTAG_SIZE-1:0] wtype_a,
  input  logic                 wdata_en,
  input  logic                 wtype_en,
  output logic [31:0]          base,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_writedata,
  output logic                 mem_read,
  output logic                 mem_write,
  input  logic [31:0]          mem_readdata,
  input  logic                 mem_waitrequest
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FILL_VAL = 3'd1;
  localparam logic [2:0] ST_FILL_TAG = 3'd2;
  localparam logic [2:0] ST_FL_SCAN  = 3'd3;
  localparam logic [2:0] ST_FL_VAL   = 3'd4;
  localparam logic [2:0] ST_FL_TAG   = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  localparam logic [1:0] OP_SETBASE = 2'd0;
  localparam logic [1:0] OP_FILL    = 2'd1;
  localparam logic [1:0] OP_FLUSH   = 2'd2;
  localparam logic [1:0] OP_INVAL   = 2'd3;

  localparam logic [IDX_W:0]   NREGS_N  = (IDX_W+1)'(NREGS);
  localparam logic [IDX_W-1:0] PTR_LAST = '1;
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

  logic [2:0]           state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     fill_last;
  logic [31:0]          base_q;
  logic [31:0]          vals [NREGS];
  logic [TTAG_SIZE-1:0] tags [NREGS];
  logic [NREGS-1:0]     dirty;

  logic [IDX_W:0]       fill_n;
  logic [31:0]          slot_addr;
  logic                 xfer_ok;
  logic                 core_wr;

  // Fills never reach past the cached window.
  assign fill_n    = (cmd_count > NREGS_N) ? NREGS_N : cmd_count;
  assign slot_addr = base_q + (32'(ptr) << SLOT_SHIFT);
  assign xfer_ok   = !mem_waitrequest;
  assign core_wr   = wdata_en || wtype_en;

  assign cmd_ready = (state == ST_IDLE);
  assign done      = (state == ST_DONE);
  assign base      = base_q;

  assign data_a = wdata_en ? wdata_a : vals[idx_a];
  assign type_a = wtype_en ? wtype_a : tags[idx_a];
  assign data_b = vals[idx_b];
  assign type_b = tags[idx_b];
  assign data_c = vals[idx_c];
  assign type_c = tags[idx_c];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      fill_last <= '0;
      base_q    <= '0;
      dirty     <= '0;
      for (int i = 0; i < NREGS; i++) begin
        vals[i] <= '0;
        tags[i] <= '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (wdata_en) vals[idx_a] <= wdata_a;
          if (wtype_en) tags[idx_a] <= wtype_a;
          if (core_wr)  dirty[idx_a] <= 1'b1;
          if (cmd_valid) begin
            ptr <= '0;
            unique case (cmd_op)
              OP_SETBASE: begin
                base_q <= cmd_base;
                state  <= ST_DONE;
              end
              OP_FILL: begin
                fill_last <= IDX_W'(fill_n - 1'b1);
                state     <= (fill_n == '0) ? ST_DONE : ST_FILL_VAL;
              end
              OP_FLUSH: state <= ST_FL_SCAN;
              OP_INVAL: begin
                // Overrides a same-cycle core tag write.
                dirty <= '0;
                for (int i = 0; i < NREGS; i++) tags[i] <= '0;
                state <= ST_DONE;
              end
            endcase
          end
        end
        ST_FILL_VAL: begin
          if (xfer_ok) begin
            vals[ptr] <= mem_readdata;
            state     <= ST_FILL_TAG;
          end
        end
        ST_FILL_TAG: begin
          if (xfer_ok) begin
            tags[ptr]  <= mem_readdata[TTAG_SIZE-1:0];
            dirty[ptr] <= 1'b0;
            if (ptr == fill_last) begin
              state <= ST_DONE;
            end else begin
              ptr   <= ptr + PTR_ONE;
              state <= ST_FILL_VAL;
            end
          end
        end
        ST_FL_SCAN: begin
          if (dirty[ptr]) begin
            state <= ST_FL_VAL;
          end else if (ptr == PTR_LAST) begin
            state <= ST_DONE;
          end else begin
            ptr <= ptr + PTR_ONE;
          end
        end
        ST_FL_VAL: begin
          if (xfer_ok) state <= ST_FL_TAG;
        end
        ST_FL_TAG: begin
          if (xfer_ok) begin
            dirty[ptr] <= 1'b0;
            if (ptr == PTR_LAST) begin
              state <= ST_DONE;
            end else begin
              ptr   <= ptr + PTR_ONE;
              state <= ST_FL_SCAN;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request outputs depend only on state/ptr/base, which hold during waits.
  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    unique case (state)
      ST_FILL_VAL: begin
        mem_read    = 1'b1;
        mem_address = slot_addr;
      end
      ST_FILL_TAG: begin
        mem_read    = 1'b1;
        mem_address = slot_addr + 32'd4;
      end
      ST_FL_VAL: begin
        mem_write     = 1'b1;
        mem_address   = slot_addr;
        mem_writedata = vals[ptr];
      end
      ST_FL_TAG: begin
        mem_write     = 1'b1;
        mem_address   = slot_addr + 32'd4;
        mem_writedata = 32'(tags[ptr]);
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_stack_regfile.sv
// Directed bench for stack_regfile: port vectors, fill/flush/inval
// sequences, wait states and mid-transfer reset against a memory model.
module tb_stack_regfile;

  localparam int NREGS = 32;
  localparam int TS    = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_base = '0;
  logic [5:0]  cmd_count = '0;
  logic        cmd_ready, done;
  logic [4:0]  idx_a = '0, idx_b = '0, idx_c = '0;
  logic [31:0] data_a, data_b, data_c;
  logic [TS-1:0] type_a, type_b, type_c;
  logic [31:0] wdata_a = '0;
  logic [TS-1:0] wtype_a = '0;
  logic        wdata_en = 1'b0, wtype_en = 1'b0;
  logic [31:0] base;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest;

  stack_regfile dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_base(cmd_base),
    .cmd_count(cmd_count), .cmd_ready(cmd_ready), .done(done),
    .idx_a(idx_a), .idx_b(idx_b), .idx_c(idx_c),
    .data_a(data_a), .data_b(data_b), .data_c(data_c),
    .type_a(type_a), .type_b(type_b), .type_c(type_c),
    .wdata_a(wdata_a), .wtype_a(wtype_a),
    .wdata_en(wdata_en), .wtype_en(wtype_en), .base(base),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Avalon slave model with programmable wait states and access log.
  logic [31:0] mem [1024];
  int          wait_n = 0;
  int          wcnt = 0;
  int          stab_err = 0;
  logic        prev_w = 1'b0, pr = 1'b0, pw = 1'b0;
  logic [31:0] pa = '0;
  logic [31:0] la [$];
  logic [31:0] ld [$];
  logic        lw [$];

  assign mem_waitrequest = (mem_read || mem_write) && (wcnt < wait_n);
  assign mem_readdata = mem_read ? mem[mem_address[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_read || mem_write) begin
      if (mem_waitrequest) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        la.push_back(mem_address);
        lw.push_back(mem_write);
        ld.push_back(mem_write ? mem_writedata : mem_readdata);
        if (mem_write) mem[mem_address[11:2]] <= mem_writedata;
      end
    end else begin
      wcnt <= 0;
    end
    if (rst && prev_w &&
        (mem_address != pa || mem_read != pr || mem_write != pw))
      stab_err <= stab_err + 1;
    if (mem_read && mem_write) stab_err <= stab_err + 1;
    prev_w <= rst && mem_waitrequest;
    pa <= mem_address;
    pr <= mem_read;
    pw <= mem_write;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clr_log();
    la.delete();
    ld.delete();
    lw.delete();
  endtask

  // Issue a command at a negedge; cyc returns the cycle in which done
  // is seen (acceptance cycle = 0). At cycle 'poke' a stray SETBASE
  // 0x2000 is presented while busy.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] b,
                         input logic [5:0] cnt, input int poke,
                         output int cyc);
    @(negedge clk);
    chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = b;
    cmd_count = cnt;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      if (done) break;
      if (cyc == poke) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_base  = 32'h2000;
      end
      if (cyc > 3000) begin
        failures++;
        $display("FAIL cmd_timeout: no done after %0d cycles", cyc);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [4:0]    ia, ib;
    logic [31:0]   wd;
    logic          wde;
    logic [TS-1:0] wt;
    logic          wte;
    logic [31:0]   ea;
    logic [TS-1:0] eta;
    logic [31:0]   eb;
    logic [TS-1:0] etb;
  } vec_t;

  vec_t vt [6];
  int   cyc;

  initial begin
    vt[0] = '{5'd5, 5'd5, 32'h42, 1'b1, 5'd0, 1'b0,
              32'h42, 5'd0, 32'h0, 5'd0};
    vt[1] = '{5'd5, 5'd5, 32'h0, 1'b0, 5'd0, 1'b0,
              32'h42, 5'd0, 32'h42, 5'd0};
    vt[2] = '{5'd7, 5'd7, 32'h99, 1'b0, 5'h1F, 1'b1,
              32'h0, 5'h1F, 32'h0, 5'd0};
    vt[3] = '{5'd7, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
              32'h0, 5'h1F, 32'h11111111, 5'd3};
    vt[4] = '{5'd0, 5'd1, 32'hCAFEF00D, 1'b1, 5'd2, 1'b1,
              32'hCAFEF00D, 5'd2, 32'h22222222, 5'd7};
    vt[5] = '{5'd1, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
              32'h22222222, 5'd7, 32'hCAFEF00D, 5'd2};

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'h11111111;
    mem[1] = 32'h00000023;
    mem[2] = 32'h22222222;
    mem[3] = 32'h00000007;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_base", base, 32'd0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_data_b", data_b, 32'd0);
    rst = 1'b1;

    // First command right after reset release
    run_cmd(2'd0, 32'h1000, 6'd0, -1, cyc);
    chk("setbase_cycle", cyc, 32'd1);
    chk("setbase_base", base, 32'h1000);

    // Zero-wait FILL of two slots
    clr_log();
    run_cmd(2'd1, 32'h0, 6'd2, -1, cyc);
    chk("fill2_cycle", cyc, 32'd5);
    chk("fill2_nacc", la.size(), 32'd4);
    if (la.size() == 4) begin
      chk("fill2_a0", la[0], 32'h1000);
      chk("fill2_a1", la[1], 32'h1004);
      chk("fill2_a2", la[2], 32'h1008);
      chk("fill2_a3", la[3], 32'h100C);
      chk("fill2_rd", {28'd0, lw[0], lw[1], lw[2], lw[3]}, 32'd0);
    end
    @(negedge clk);
    idx_b = 5'd0;
    idx_c = 5'd1;
    #1;
    chk("fill2_d0", data_b, 32'h11111111);
    chk("fill2_t0", {27'd0, type_b}, 32'd3);
    chk("fill2_d1", data_c, 32'h22222222);
    chk("fill2_t1", {27'd0, type_c}, 32'd7);

    // Clean cache: flush writes nothing
    clr_log();
    run_cmd(2'd2, 32'h0, 6'd0, -1, cyc);
    chk("flush_clean_cycle", cyc, NREGS + 1);
    chk("flush_clean_nacc", la.size(), 32'd0);

    // Dirty slot 3, then flush
    @(negedge clk);
    idx_a = 5'd3;
    wdata_a = 32'hDEADBEEF;
    wtype_a = 5'd1;
    wdata_en = 1'b1;
    wtype_en = 1'b1;
    @(negedge clk);
    wdata_en = 1'b0;
    wtype_en = 1'b0;
    clr_log();
    run_cmd(2'd2, 32'h0, 6'd0, -1, cyc);
    chk("flush3_cycle", cyc, NREGS + 3);
    chk("flush3_nacc", la.size(), 32'd2);
    if (la.size() == 2) begin
      chk("flush3_a0", la[0], 32'h1018);
      chk("flush3_d0", ld[0], 32'hDEADBEEF);
      chk("flush3_a1", la[1], 32'h101C);
      chk("flush3_d1", ld[1], 32'd1);
      chk("flush3_wr", {30'd0, lw[0], lw[1]}, 32'd3);
    end
    clr_log();
    run_cmd(2'd2, 32'h0, 6'd0, -1, cyc);
    chk("flush_again_cycle", cyc, NREGS + 1);
    chk("flush_again_nacc", la.size(), 32'd0);

    // Port vectors: bypass on a, old data on b/c
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idx_a = vt[i].ia;
      idx_b = vt[i].ib;
      idx_c = vt[i].ib;
      wdata_a = vt[i].wd;
      wdata_en = vt[i].wde;
      wtype_a = vt[i].wt;
      wtype_en = vt[i].wte;
      #1;
      chk($sformatf("vec%0d_data_a", i), data_a, vt[i].ea);
      chk($sformatf("vec%0d_type_a", i), {27'd0, type_a}, {27'd0, vt[i].eta});
      chk($sformatf("vec%0d_data_b", i), data_b, vt[i].eb);
      chk($sformatf("vec%0d_type_b", i), {27'd0, type_b}, {27'd0, vt[i].etb});
      chk($sformatf("vec%0d_data_c", i), data_c, vt[i].eb);
    end
    @(negedge clk);
    wdata_en = 1'b0;
    wtype_en = 1'b0;

    // INVAL: tags to nil, values kept, nothing dirty; stray command ignored
    run_cmd(2'd3, 32'h0, 6'd0, -1, cyc);
    chk("inval_cycle", cyc, 32'd1);
    @(negedge clk);
    idx_b = 5'd5;
    idx_c = 5'd0;
    #1;
    chk("inval_d5", data_b, 32'h42);
    chk("inval_t5", {27'd0, type_b}, 32'd0);
    chk("inval_d0", data_c, 32'hCAFEF00D);
    chk("inval_t0", {27'd0, type_c}, 32'd0);
    clr_log();
    run_cmd(2'd2, 32'h0, 6'd0, 3, cyc);
    chk("inval_flush_cycle", cyc, NREGS + 1);
    chk("inval_flush_nacc", la.size(), 32'd0);
    chk("busy_cmd_ignored", base, 32'h1000);

    // FILL 1 with 3 wait states per access
    mem[0] = 32'hABCD0123;
    mem[1] = 32'h00000015;
    wait_n = 3;
    clr_log();
    run_cmd(2'd1, 32'h0, 6'd1, -1, cyc);
    chk("fillw_cycle", cyc, 32'd9);
    chk("fillw_nacc", la.size(), 32'd2);
    chk("fillw_stable", stab_err, 32'd0);
    @(negedge clk);
    idx_b = 5'd0;
    #1;
    chk("fillw_d0", data_b, 32'hABCD0123);
    chk("fillw_t0", {27'd0, type_b}, 32'h15);
    wait_n = 0;

    // FILL count 0 and count NREGS+1
    clr_log();
    run_cmd(2'd1, 32'h0, 6'd0, -1, cyc);
    chk("fill0_cycle", cyc, 32'd1);
    chk("fill0_nacc", la.size(), 32'd0);
    clr_log();
    run_cmd(2'd1, 32'h0, 6'(NREGS + 1), -1, cyc);
    chk("fillmax_cycle", cyc, 2 * NREGS + 1);
    chk("fillmax_nacc", la.size(), 2 * NREGS);
    if (la.size() > 0)
      chk("fillmax_last_addr", la[la.size()-1], 32'h10FC);

    // Reset in the middle of a waiting flush write
    @(negedge clk);
    idx_a = 5'd3;
    wdata_a = 32'h5555;
    wdata_en = 1'b1;
    @(negedge clk);
    wdata_en = 1'b0;
    wait_n = 100;
    cmd_valid = 1'b1;
    cmd_op = 2'd2;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_write) break;
    end
    chk("midrst_wr_before", {31'd0, mem_write}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_wr_after", {31'd0, mem_write}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_base", base, 32'd0);
    @(negedge clk);
    wait_n = 0;
    rst = 1'b1;
    run_cmd(2'd0, 32'h1000, 6'd0, -1, cyc);
    chk("midrst_setbase", base, 32'h1000);
    clr_log();
    run_cmd(2'd2, 32'h0, 6'd0, -1, cyc);
    chk("midrst_flush_cycle", cyc, NREGS + 1);
    chk("midrst_flush_nacc", la.size(), 32'd0);
    chk("stable_total", stab_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_regfile.md
STACK_REGFILE -- requirements
Module: stack_regfile

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of cached Lua stack slots (power of 2, 2..256); IDX_W = log2(NREGS) is derived.
REQ-002 SHALL have parameter TTAG_SIZE, default 5, type-tag width.
REQ-003 SHALL have parameter SLOT_SHIFT, default 3, log2 of TValue size in bytes.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request; cmd_op  input  2  0=SETBASE, 1=FILL, 2=FLUSH, 3=INVAL.
REQ-007 cmd_base  input  32  new base byte address (SETBASE); cmd_count  input  IDX_W+1  slot count (FILL).
REQ-008 cmd_ready  output  1  high only in IDLE; done  output  1  one-cycle completion pulse.
REQ-009 idx_a/idx_b/idx_c  input  IDX_W  slot indices; data_a/b/c  output  32 and type_a/b/c  output  TTAG_SIZE are combinational reads.
REQ-010 wdata_a  input  32, wtype_a  input  TTAG_SIZE, wdata_en, wtype_en  input  1  core write to slot idx_a.
REQ-011 base  output  32  current base register.
REQ-012 mem_address, mem_writedata  output  32; mem_read, mem_write  output  1; mem_readdata  input  32; mem_waitrequest  input  1  Avalon-MM master.

Function
REQ-013 Command is accepted when cmd_valid && cmd_ready; the acceptance cycle is cycle 0.
REQ-014 FSM states: IDLE, FILL_VAL, FILL_TAG, FLUSH_SCAN, FLUSH_VAL, FLUSH_TAG, DONE; done=1 only in DONE, which always returns to IDLE next cycle.
REQ-015 SETBASE/INVAL: effect applied at cycle 0 edge, DONE in cycle 1; INVAL clears all dirty bits and sets all tags to 0 (nil), values untouched.
REQ-016 FILL: slots 0..min(cmd_count,NREGS)-1 in order; per slot read value at base+(i<<SLOT_SHIFT), then tag at same+4, tag = readdata[TTAG_SIZE-1:0]; filled slot dirty bit cleared; count 0 goes straight to DONE.
REQ-017 FLUSH: scan slots 0..NREGS-1, one cycle per clean slot in FLUSH_SCAN; dirty slot writes value then zero-extended tag to the same addresses as FILL, then dirty cleared.
REQ-018 Avalon: address/read/write/writedata held stable while waitrequest=1; a transfer completes in a cycle with request high and waitrequest=0; readdata captured that cycle; read and write never asserted together; all master outputs 0 in IDLE/DONE.
REQ-019 Zero-wait FILL of N slots: done high in cycle 2N+1.
REQ-020 Core write (IDLE only; ignored in other states): on clk edge update value and/or tag of idx_a and set its dirty bit.
REQ-021 Bypass: data_a/type_a return wdata_a/wtype_a in the same cycle when the respective enable is high; ports b/c have no bypass.
REQ-022 Read/write to the same slot in the same cycle on ports b/c returns the old contents.
REQ-023 cmd_valid while cmd_ready=0 is ignored, not queued.

Reset
REQ-024 On rst=0 at any time, including mid-transfer: state=IDLE, all values/tags/dirty bits/base=0, master outputs 0, done=0, cmd_ready=1, asynchronously.
REQ-025 After rst deasserts, the first command is accepted at the next clk edge with cmd_valid=1.

Verification
REQ-026 SETBASE 0x1000, FILL count 2, zero wait -> reads at 0x1000,0x1004,0x1008,0x100C; done in cycle 5; slot regs/tags match memory.
REQ-027 Write slot 3 = 0xDEADBEEF, tag 1; FLUSH -> exactly two writes, 0xDEADBEEF to base+0x18 and 1 to base+0x1C; second FLUSH -> no writes, done after NREGS+1 cycles.
REQ-028 waitrequest high for 3 cycles on each access during FILL count 1 -> address/read stable while waiting; done in cycle 9.
REQ-029 wdata_en with idx_a=idx_b=5, wdata=0x42 -> data_a=0x42 same cycle, data_b old value, both 0x42 next cycle.
REQ-030 rst=0 during FLUSH_VAL with waitrequest high -> mem_write drops immediately, all dirty bits 0, cmd_ready=1.
REQ-031 FILL count NREGS+1 -> exactly NREGS slots read, no access beyond slot NREGS-1.
